// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WRITE   = 3'd2,
    HOLD    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer flips to the loser on every grant.
module rr_arbiter_2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_vld_o,
  output logic       gnt_id_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld_o = en_i && (|req_i);
    if (&req_i) gnt_id_o = ptr_q;
    else        gnt_id_o = req_i[1] ? PORT1 : PORT0;
    ptr_d = gnt_vld_o ? ~gnt_id_o : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= PORT0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Arbitrates two request/ack ports onto one single-port RAM with a
// setup/strobe/hold write sequence and a registered read capture.
module ram_arbiter_2port
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_is_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  state_e                       state_q, state_d;
  logic                         win_q, we_q, wr_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            wdata_q;
  logic [1:0]                   ack_q;
  logic [1:0][DATA_W-1:0]       rdata_q;
  logic [1:0]                   req, we;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       wdata;
  logic                         gnt_vld, gnt_id;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req),
    .en_i      (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_id_o  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = SETUP;
      SETUP:   state_d = we_q ? WRITE : CAPTURE;
      WRITE:   state_d = HOLD;
      HOLD:    state_d = DONE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe and acks are decoded from the next state so they come
  // straight off flops, aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= (state_d == WRITE);
      ack_q   <= '0;
      if (state_d == DONE) ack_q[win_q] <= 1'b1;
      if (state_q == IDLE && gnt_vld) begin
        win_q   <= gnt_id;
        we_q    <= we[gnt_id];
        addr_q  <= addr[gnt_id];
        wdata_q <= wdata[gnt_id];
      end
      if (state_q == CAPTURE) rdata_q[win_q] <= ram_out;
    end
  end

  assign ram_address  = addr_q;
  assign ram_in       = wdata_q;
  assign ram_is_write = wr_q;
  assign p0_ack       = ack_q[0];
  assign p1_ack       = ack_q[1];
  assign p0_rdata     = rdata_q[0];
  assign p1_rdata     = rdata_q[1];
  assign busy         = (state_q != IDLE);

endmodule
